// File: rtl/mem_msg_master.sv
// CPU-side master for the simulation memory link: packs core requests
// into channel-0 messages and returns read data from response messages.
module mem_msg_master (
   input  logic        CLK,
   input  logic        RST,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_mask,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        err,
   output logic        msg_send_flag,
   output logic [4:0]  msg_send_length,
   output logic [71:0] msg_send_data,
   input  logic        msg_sendable,
   input  logic        msg_recvable,
   input  logic [4:0]  msg_recv_length,
   input  logic [71:0] msg_recv_data,
   output logic        msg_recv_flag
);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT
   } state_e;

   state_e      state_q;
   logic        write_q;
   logic        holdoff_q;
   logic        resp_valid_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        send_flag_q;
   logic [4:0]  send_len_q;
   logic [71:0] send_data_q;
   logic        recv_flag_q;

   logic [4:0]  send_len_d;
   logic [71:0] send_data_d;
   logic        pop_ok;
   logic        unused_recv_bits;

   // Transport status lags a pop by one cycle, so ignore it right after one.
   assign pop_ok    = msg_recvable && !holdoff_q;
   assign req_ready = (state_q == IDLE);

   assign unused_recv_bits = ^msg_recv_data[71:32];

   always_comb begin
      send_len_d  = 5'd5;
      send_data_d = {40'h0, req_addr};
      if (req_write) begin
         send_len_d  = 5'd9;
         send_data_d = {4'h0, req_mask, req_addr, req_wdata};
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= IDLE;
         write_q      <= 1'b0;
         holdoff_q    <= 1'b0;
         resp_valid_q <= 1'b0;
         rdata_q      <= 32'h0;
         err_q        <= 1'b0;
         send_flag_q  <= 1'b0;
         send_len_q   <= 5'd0;
         send_data_q  <= 72'h0;
         recv_flag_q  <= 1'b0;
      end else begin
         send_flag_q  <= 1'b0;
         recv_flag_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         holdoff_q    <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (req_valid) begin
                  send_len_q  <= send_len_d;
                  send_data_q <= send_data_d;
                  write_q     <= req_write;
                  state_q     <= SEND;
               end
               if (pop_ok) begin
                  recv_flag_q <= 1'b1;
                  holdoff_q   <= 1'b1;
                  err_q       <= 1'b1;
               end
            end
            SEND: begin
               if (pop_ok) begin
                  recv_flag_q <= 1'b1;
                  holdoff_q   <= 1'b1;
                  err_q       <= 1'b1;
               end
               if (msg_sendable) begin
                  send_flag_q <= 1'b1;
                  // Writes complete on the push; the memory never acks them.
                  if (write_q) begin
                     resp_valid_q <= 1'b1;
                     state_q      <= IDLE;
                  end else begin
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (pop_ok) begin
                  recv_flag_q  <= 1'b1;
                  holdoff_q    <= 1'b1;
                  resp_valid_q <= 1'b1;
                  rdata_q      <= msg_recv_data[31:0];
                  if (msg_recv_length != 5'd4) err_q <= 1'b1;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign resp_valid      = resp_valid_q;
   assign resp_rdata      = rdata_q;
   assign err             = err_q;
   assign msg_send_flag   = send_flag_q;
   assign msg_send_length = send_len_q;
   assign msg_send_data   = send_data_q;
   assign msg_recv_flag   = recv_flag_q;

endmodule

// File: doc/mem_msg_master.md
# mem_msg_master

CPU-side master for the simulation memory link. It accepts single 32-bit memory requests from the core, packs each into one 72-bit channel message, and hands it to channel 0 of the multichannel transport. For reads it waits for the 4-byte response message, pops it, and returns the data to the core. It sits directly upstream of the UART-attached simulation memory, on the FPGA/CPU side of the link.

## Interface
- No parameters; all widths are fixed by the message format.
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- req_valid  in  1  core request present
- req_ready  out  1  high exactly when state==IDLE; request accepted on a CLK edge with req_valid&&req_ready
- req_write  in  1  1=write, 0=read
- req_addr  in  32  byte address, passed through unaligned
- req_wdata  in  32  write data, byte 0 in [7:0]
- req_mask  in  4  byte-enable, bit i enables byte i
- resp_valid  out  1  one-cycle completion pulse (reads and writes)
- resp_rdata  out  32  read data; holds until the next read completes
- err  out  1  sticky protocol-error flag; cleared only by RST
- msg_send_flag  out  1  one-cycle push to transport channel 0
- msg_send_length  out  5  message length in bytes
- msg_send_data  out  72  message payload
- msg_sendable  in  1  transport can accept a push this cycle
- msg_recvable  in  1  transport holds a received message
- msg_recv_length  in  5  length of the held message
- msg_recv_data  in  72  payload of the held message
- msg_recv_flag  out  1  one-cycle pop of the held message

## Operation
- Message formats (must match the memory side):
  - Read: length 5; data[31:0]=addr, data[39:32]=0x00, rest 0.
  - Write: length 9; data[31:0]=wdata, [63:32]=addr, [67:64]=mask, [71:68]=0.
  - Response: length 4; data[31:0]=read word.
- Payload and length are latched at acceptance and held stable until the next acceptance.
- FSM states: IDLE, SEND, WAIT.
  - IDLE: on accept, go to SEND.
  - SEND: when msg_sendable=1, register msg_send_flag=1. A write then goes to IDLE with resp_valid=1 in the same cycle as the push; there is no memory ack. A read goes to WAIT. If msg_sendable=0, stay in SEND.
  - WAIT: when msg_recvable=1 and holdoff=0, register msg_recv_flag=1, resp_rdata<=msg_recv_data[31:0], resp_valid=1, holdoff=1, and go to IDLE.
- holdoff: set on every pop and cleared the following cycle. While holdoff=1, msg_recvable is ignored because the transport status lags the pop by one cycle.
- Response with msg_recv_length≠4: data is still delivered and err is set.
- Stray message (msg_recvable=1, holdoff=0) in IDLE or SEND: popped, discarded, err set. In the IDLE case, the pop does not block acceptance of a new request.
- A write with mask 0 is still sent as a 9-byte message.
- Reset mid-operation: returns to IDLE and abandons any in-flight request. A response that arrives later is treated as stray.

## Timing
- Reset values: state IDLE (so req_ready=1), resp_valid=0, resp_rdata=0, err=0, msg_send_flag=0, msg_send_length=0, msg_send_data=0, msg_recv_flag=0, holdoff=0.
- Accept at edge t0.
  - Push registered at the first edge t≥t1 with msg_sendable=1; minimum push latency is 1 cycle after acceptance.
  - Write: resp_valid coincides with msg_send_flag. Back-to-back writes run one per 2 cycles.
  - Read: resp_valid asserts 1 cycle after the first sampled msg_recvable=1 in WAIT.
- All outputs except req_ready are registered. msg_send_flag, msg_recv_flag and resp_valid are never high for two consecutive cycles.
- Minimum spacing between pops is 2 cycles.

## Test plan
- Read addr 0x00000010, with the transport returning length 4, data 0x11223344 → pushed message has length 5 and data 0x00_00000010; one pop; resp_rdata=0x11223344; err=0.
- Write addr 0x100, wdata 0xDEADBEEF, mask 0b0101 → length 9, data {0x05, 0x00000100, 0xDEADBEEF}; resp_valid in the same cycle as the push; no pop.
- msg_sendable held low for 5 cycles after acceptance → exactly one push, in the first cycle after msg_sendable rises; req_ready=0 throughout.
- msg_recvable held high for 3 cycles in WAIT → exactly one pop; the following message is treated as stray (popped, err=1).
- Response length 3, data 0xCAFE0001 → resp_rdata=0xCAFE0001 and err=1, with err remaining set until RST.
- RST asserted while in WAIT → all outputs reach reset values asynchronously; a subsequent read completes normally.
